// File: rtl/alwaysff_resp_checker.sv
// Response checker for the always_ff clock/reset test DUT: models z/y/x, compares them in CHECK, and reports pass/fail.
// Optional: define ALWAYSFF_CHK_STOP_ON_FAIL_EN to end CHECK on the first mismatching cycle.
module alwaysff_resp_checker #(
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_srst,
  input  logic             i_dut_arst,
  input  logic             i_w,
  input  logic             i_z,
  input  logic             i_y,
  input  logic             i_x,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [2:0]       o_fail_vec,
  output logic [CNT_W-1:0] o_first_fail_cyc
);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETL, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d, len_q, len_d;
  logic [ERR_W-1:0] err_d;
  logic [2:0]       fail_d;
  logic [CNT_W-1:0] first_d;
  logic             exp_y_q, exp_x_q;
  logic [2:0]       mis;
  logic             any_mis, stop;

  // The DUT's async reset clears x immediately, so it takes priority over the registered model.
  assign mis[0]  = i_z;
  assign mis[1]  = (i_y != exp_y_q);
  assign mis[2]  = i_dut_arst ? i_x : (i_x != exp_x_q);
  assign any_mis = |mis;

`ifdef ALWAYSFF_CHK_STOP_ON_FAIL_EN
  assign stop = any_mis;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    err_d     = o_err_cnt;
    fail_d    = o_fail_vec;
    first_d   = o_first_fail_cyc;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_SETL;
          set_cnt_d = '0;
          idx_d     = '0;
          len_d     = i_len;
          err_d     = '0;
          fail_d    = '0;
          first_d   = '0;
        end
      end
      S_SETL: begin
        if (set_cnt_q == SET_W'(SETTLE - 1))
          state_d = (len_q == '0) ? S_DONE : S_CHECK;
        else
          set_cnt_d = set_cnt_q + SET_W'(1);
      end
      S_CHECK: begin
        if (any_mis) begin
          if (!(&o_err_cnt)) err_d = o_err_cnt + ERR_W'(1);
          fail_d = o_fail_vec | mis;
          if (o_err_cnt == '0) first_d = idx_q;
        end
        if ((idx_q == len_q - CNT_W'(1)) || stop)
          state_d = S_DONE;
        else
          idx_d = idx_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q          <= S_IDLE;
      set_cnt_q        <= '0;
      idx_q            <= '0;
      len_q            <= '0;
      exp_y_q          <= 1'b0;
      exp_x_q          <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_cnt        <= '0;
      o_fail_vec       <= '0;
      o_first_fail_cyc <= '0;
    end else begin
      state_q          <= state_d;
      set_cnt_q        <= set_cnt_d;
      idx_q            <= idx_d;
      len_q            <= len_d;
      exp_y_q          <= ~i_srst;
      exp_x_q          <= i_dut_arst ? 1'b0 : i_w;
      o_busy           <= (state_d == S_SETL) || (state_d == S_CHECK);
      o_done           <= (state_d == S_DONE);
      o_pass           <= (state_d == S_DONE) && (err_d == '0);
      o_err_cnt        <= err_d;
      o_fail_vec       <= fail_d;
      o_first_fail_cyc <= first_d;
    end
  end
endmodule

// File: doc/alwaysff_resp_checker.md
# alwaysff_resp_checker

Cycle-accurate response checker for the always_ff clocking/reset test hierarchy: it drives nothing into the DUT, but samples the DUT's `z`, `y`, `x` outputs, models their expected values, and reports the result. Expected behaviour:
- `z` is constant 0.
- `y` is a sync-reset flop of constant 1.
- `x` is an async-reset flop of `w`.

The checker sits beside the DUT top in the bench/emulation wrapper. It is the receiving end that turns the DUT's registered outputs into pass/fail status, mismatch counts and first-failure data.

## Interface
Parameters:
- `CNT_W`, 16, width of the check-length input and of the cycle-index capture.
- `ERR_W`, 8, width of the saturating mismatch counter.
- `SETTLE`, 2, cycles after start during which models prime and no compare occurs (≥1).

Ports:
- `i_clk`  in  1  single clock; all sampling on rising edge.
- `i_arst`  in  1  checker reset, asynchronous, active-low.
- `i_start`  in  1  start pulse; honoured only in IDLE or DONE.
- `i_len`  in  CNT_W  number of CHECK cycles; sampled with `i_start`.
- `i_srst`  in  1  DUT sync reset as driven to the DUT, active-high.
- `i_dut_arst`  in  1  DUT async reset as driven to the DUT, active-high.
- `i_w`  in  1  DUT data stimulus.
- `i_z`, `i_y`, `i_x`  in  1 each  observed DUT outputs.
- `o_busy`  out  1  high in SETTLE or CHECK.
- `o_done`  out  1  high in DONE.
- `o_pass`  out  1  `o_done` and zero mismatches.
- `o_err_cnt`  out  ERR_W  mismatch cycles, saturating at all-ones.
- `o_fail_vec`  out  3  sticky per-signal mismatch, bit order {x,y,z}.
- `o_first_fail_cyc`  out  CNT_W  CHECK-cycle index (0-based) of the first mismatch.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE on `i_start`.
  - SETTLE → CHECK after `SETTLE` cycles.
  - CHECK → DONE after `i_len` compare cycles.
  - DONE → SETTLE on `i_start`.
- On each start, the checker clears the counters, `o_fail_vec` and `o_first_fail_cyc`, and latches `i_len`.
- `i_start` in SETTLE or CHECK is ignored.
- `i_len`=0: SETTLE then DONE directly; `o_pass`=1.
- Models run every cycle in every state. They reset only with `i_arst`.
  - `exp_y_q <= ~i_srst`.
  - `exp_x_q <= i_dut_arst ? 0 : i_w`.
- Compare, evaluated only in CHECK at each edge:
  - `z` mismatch: `i_z != 0`.
  - `y` mismatch: `i_y != exp_y_q`.
  - `x` mismatch:
    - If `i_dut_arst`=1: `i_x != 0`. The async reset overrides immediately.
    - Otherwise: `i_x != exp_x_q`.
- Mismatch cycle (any bit set):
  - `o_err_cnt` increments by one per cycle, not per bit, and saturates.
  - The mismatch bits are OR-ed into `o_fail_vec`.
  - If this is the first mismatch since start, the current CHECK index is captured.
- CHECK index counts 0..`i_len`-1.

## Timing
- All outputs are registered. Reset value (while `i_arst`=0):
  - state IDLE.
  - `o_busy`/`o_done`/`o_pass`=0.
  - `o_err_cnt`=0, `o_fail_vec`=0, `o_first_fail_cyc`=0.
  - `exp_y_q`=0, `exp_x_q`=0.
- `i_start` sampled at edge T:
  - `o_busy`=1 from T+1.
  - The first compare happens at edge T+`SETTLE`+1.
  - `o_done`=1 from T+`SETTLE`+`i_len`+1.
- Mismatch sampled at edge E: `o_err_cnt`/`o_fail_vec`/`o_first_fail_cyc` are updated at E and visible after E.
- `i_arst` asserted mid-run: the checker returns to IDLE asynchronously and all results are lost.
- `i_dut_arst` is sampled synchronously. It must be stable around the edge; the bench owns its alignment.

## Configuration
- `ALWAYSFF_CHK_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch cycle forces CHECK → DONE at that edge. `o_err_cnt` ends at 1.
  - Undefined: CHECK always runs the full `i_len` cycles and counts every mismatch.

## Test plan
- Correct DUT model, `i_len`=20, `i_srst` toggled at index 5, `i_w` random → `o_done` after 23 cycles, `o_pass`=1, `o_err_cnt`=0, `o_fail_vec`=000.
- `i_z` forced 1 at CHECK indices 3..6, `i_len`=10 → `o_err_cnt`=4, `o_fail_vec`=001, `o_first_fail_cyc`=3; with the macro defined → `o_err_cnt`=1, DONE at index 3.
- `i_x` delayed one extra cycle vs `i_w`, `i_w`=1010… → x mismatches every cycle, `o_fail_vec`=100, `o_first_fail_cyc`=0.
- `i_dut_arst`=1 at index 4 with `i_x` still 1 → single x mismatch at 4; with `i_x`=0 there → no error.
- `i_arst` pulsed low at CHECK index 7 → IDLE, all outputs 0; a new `i_start` then runs a clean check.
- `ERR_W`=2, 6 mismatching cycles → `o_err_cnt`=3 (saturated); `i_start` during CHECK is ignored; `i_len`=0 → `o_pass`=1 after 3 cycles.
